// File: rtl/cpu_pkg.sv
// Opcode map, opcode class helpers and issue FSM encoding shared by the
// issue stage and its hazard scoreboard.
package cpu_pkg;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_MOVE  = 6'd3;
    localparam logic [5:0] OP_SGE   = 6'd4;
    localparam logic [5:0] OP_SLE   = 6'd5;
    localparam logic [5:0] OP_SGT   = 6'd6;
    localparam logic [5:0] OP_SLT   = 6'd7;
    localparam logic [5:0] OP_SEQ   = 6'd8;
    localparam logic [5:0] OP_SNE   = 6'd9;
    localparam logic [5:0] OP_AND   = 6'd10;
    localparam logic [5:0] OP_OR    = 6'd11;
    localparam logic [5:0] OP_XOR   = 6'd12;
    localparam logic [5:0] OP_NOT   = 6'd13;
    localparam logic [5:0] OP_MOVEI = 6'd14;
    localparam logic [5:0] OP_SLI   = 6'd15;
    localparam logic [5:0] OP_SRI   = 6'd16;
    localparam logic [5:0] OP_ADDI  = 6'd17;
    localparam logic [5:0] OP_SUBI  = 6'd18;
    localparam logic [5:0] OP_LOAD  = 6'd19;
    localparam logic [5:0] OP_STORE = 6'd20;
    localparam logic [5:0] OP_JUMP  = 6'd21;
    localparam logic [5:0] OP_BRA   = 6'd22;
    localparam logic [5:0] OP_ADDF  = 6'd23;
    localparam logic [5:0] OP_MULF  = 6'd24;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        BR_WAIT = 2'd2,
        FLUSH   = 2'd3
    } state_e;

    // Codes above MULF are undefined and behave as NOP.
    function automatic logic is_defined(input logic [5:0] op);
        return op <= OP_MULF;
    endfunction

    function automatic logic writes_reg(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MOVE, OP_SGE, OP_SLE, OP_SGT, OP_SLT,
            OP_SEQ, OP_SNE, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOVEI,
            OP_SLI, OP_SRI, OP_ADDI, OP_SUBI, OP_LOAD, OP_ADDF,
            OP_MULF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [5:0] op);
        return is_defined(op) &&
               !(op inside {OP_NOP, OP_MOVEI, OP_JUMP});
    endfunction

    function automatic logic uses_rs2(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_STORE, OP_SGE, OP_SLE, OP_SGT, OP_SLT,
            OP_SEQ, OP_SNE, OP_AND, OP_OR, OP_XOR, OP_ADDF,
            OP_MULF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_JUMP) || (op == OP_BRA);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight writers (EX, MEM, WB) and RAW comparator.
// Ports: ld_* = instruction issued this cycle (ld_v=0 for a bubble);
// id_* = candidate in decode; hazard = candidate reads a pending rd.
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int HAZ_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_v,
    input  logic              ld_wr,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              hazard
);

    logic [HAZ_DEPTH-1:0]             v_q, v_d;
    logic [HAZ_DEPTH-1:0]             wr_q, wr_d;
    logic [HAZ_DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;

    always_comb begin
        v_d     = v_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        v_d[0]  = ld_v;
        wr_d[0] = ld_wr;
        rd_d[0] = ld_rd;
        for (int i = 1; i < HAZ_DEPTH; i++) begin
            v_d[i]  = v_q[i-1];
            wr_d[i] = wr_q[i-1];
            rd_d[i] = rd_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q  <= '0;
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            v_q  <= v_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    logic use1, use2, hit;

    always_comb begin
        use1 = uses_rs1(id_opcode);
        use2 = uses_rs2(id_opcode);
        hit  = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (v_q[i] && wr_q[i] &&
                ((use1 && rd_q[i] == id_rs1) ||
                 (use2 && rd_q[i] == id_rs2)))
                hit = 1'b1;
        end
        hazard = id_valid && hit;
    end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Issue stage: stalls on RAW hazards and squashes wrong-path fetches.
// Ports: id_* candidate in, ex_br_taken from EX; stall/flush to fetch,
// issue_valid/issue_opcode (registered) to decoder, state_o for debug.
module issue_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int HAZ_DEPTH  = 3,
    parameter int BR_PENALTY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              ex_br_taken,
    output logic              stall,
    output logic              issue_valid,
    output logic [5:0]        issue_opcode,
    output logic              flush,
    output logic [1:0]        state_o
);

    localparam int CW = $clog2(BR_PENALTY + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              iv_q, iv_d;
    logic [5:0]        op_q, op_d;
    logic              ld_v, ld_wr;
    logic [REG_AW-1:0] ld_rd;
    logic              hazard, issue_path, taken;

    hazard_scoreboard #(
        .REG_AW    (REG_AW),
        .HAZ_DEPTH (HAZ_DEPTH)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .ld_v      (ld_v),
        .ld_wr     (ld_wr),
        .ld_rd     (ld_rd),
        .id_valid  (id_valid),
        .id_opcode (id_opcode),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .hazard    (hazard)
    );

    // In BR_WAIT the branch issued last cycle is still on issue_opcode.
    assign taken = (op_q == OP_JUMP) || ex_br_taken;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        iv_d       = 1'b0;
        op_d       = OP_NOP;
        ld_v       = 1'b0;
        ld_wr      = 1'b0;
        ld_rd      = '0;
        stall      = 1'b0;
        flush      = 1'b0;
        issue_path = 1'b0;

        unique case (state_q)
            RUN, STALL: issue_path = 1'b1;
            BR_WAIT: begin
                if (taken) begin
                    // Flush wins: hazards on wrong-path code never stall.
                    flush   = 1'b1;
                    cnt_d   = CW'(BR_PENALTY - 1);
                    state_d = (BR_PENALTY > 1) ? FLUSH : RUN;
                end else begin
                    issue_path = 1'b1;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_d == '0)
                    state_d = RUN;
            end
        endcase

        if (issue_path) begin
            if (hazard) begin
                stall   = 1'b1;
                state_d = STALL;
            end else begin
                state_d = RUN;
                if (id_valid && is_defined(id_opcode) &&
                    id_opcode != OP_NOP) begin
                    iv_d  = 1'b1;
                    op_d  = id_opcode;
                    ld_v  = 1'b1;
                    ld_wr = writes_reg(id_opcode);
                    ld_rd = id_rd;
                    if (is_branch(id_opcode))
                        state_d = BR_WAIT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            iv_q    <= 1'b0;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            iv_q    <= iv_d;
            op_q    <= op_d;
        end
    end

    assign issue_valid  = iv_q;
    assign issue_opcode = op_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Directed bench for issue_hazard_ctrl: per-cycle expectations are queued
// by the stimulus and checked by an independent monitor on negedge.
module tb_issue_hazard_ctrl;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [5:0] id_opcode = OP_NOP;
    logic [4:0] id_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic       ex_br_taken = 1'b0;
    logic       stall, issue_valid, flush;
    logic [5:0] issue_opcode;
    logic [1:0] state_o;

    issue_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_rd        (id_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_br_taken  (ex_br_taken),
        .stall        (stall),
        .issue_valid  (issue_valid),
        .issue_opcode (issue_opcode),
        .flush        (flush),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [10:0] e;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   row = 0;

    // Expectation layout: {stall, flush, issue_valid, issue_opcode, state}
    task automatic step(input logic r, input logic v, input logic [5:0] op,
                        input int rd, input int s1, input int s2,
                        input logic tk, input logic e_st, input logic e_fl,
                        input logic e_iv, input logic [5:0] e_op,
                        input state_e e_s);
        exp_t x;
        @(posedge clk);
        #1;
        rst         = r;
        id_valid    = v;
        id_opcode   = op;
        id_rd       = 5'(rd);
        id_rs1      = 5'(s1);
        id_rs2      = 5'(s2);
        ex_br_taken = tk;
        row++;
        x.idx = row;
        x.e   = {e_st, e_fl, e_iv, e_op, e_s};
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t        x;
        logic [10:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x   = exp_q.pop_front();
                act = {stall, flush, issue_valid, issue_opcode, state_o};
                checks++;
                if (act === x.e)
                    passes++;
                else
                    $display("FAIL row%0d got=%b exp=%b (st fl iv op6 s2)",
                             x.idx, act, x.e);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : stim
        //   rst v  op        rd s1 s2 tk  st fl iv exp_op    state
        // reset, then back-to-back ADD r3 -> SUB r4,r3,r5
        step(1, 0, OP_NOP,    0, 0, 0, 0,  0, 0, 0, OP_NOP,   RUN);
        step(0, 1, OP_ADD,    3, 1, 2, 0,  0, 0, 0, OP_NOP,   RUN);
        step(0, 1, OP_SUB,    4, 3, 5, 0,  1, 0, 1, OP_ADD,   RUN);
        step(0, 1, OP_SUB,    4, 3, 5, 0,  1, 0, 0, OP_NOP,   STALL);
        step(0, 1, OP_SUB,    4, 3, 5, 0,  1, 0, 0, OP_NOP,   STALL);
        step(0, 1, OP_SUB,    4, 3, 5, 0,  0, 0, 0, OP_NOP,   STALL);
        step(0, 0, OP_NOP,    0, 0, 0, 0,  0, 0, 1, OP_SUB,   RUN);
        // distance-2: ADD r3, OR r7, AND r8,r3,r1
        step(0, 1, OP_ADD,    3, 1, 2, 0,  0, 0, 0, OP_NOP,   RUN);
        step(0, 1, OP_OR,     7, 5, 6, 0,  0, 0, 1, OP_ADD,   RUN);
        step(0, 1, OP_AND,    8, 3, 1, 0,  1, 0, 1, OP_OR,    RUN);
        step(0, 1, OP_AND,    8, 3, 1, 0,  1, 0, 0, OP_NOP,   STALL);
        step(0, 1, OP_AND,    8, 3, 1, 0,  0, 0, 0, OP_NOP,   STALL);
        // STORE (rd field r2) then LOAD r6 from r2; MOVEI r9; SLI r1,r2
        step(0, 1, OP_STORE,  2, 2, 9, 0,  0, 0, 1, OP_AND,   RUN);
        step(0, 1, OP_LOAD,   6, 2, 0, 0,  0, 0, 1, OP_STORE, RUN);
        step(0, 1, OP_MOVEI,  9, 6, 6, 0,  0, 0, 1, OP_LOAD,  RUN);
        step(0, 1, OP_SLI,    1, 2, 9, 0,  0, 0, 1, OP_MOVEI, RUN);
        // taken BRA; wrong-path ADD r3 held in decode
        step(0, 1, OP_BRA,    0, 5, 0, 0,  0, 0, 1, OP_SLI,   RUN);
        step(0, 1, OP_ADD,    3, 1, 2, 1,  0, 1, 1, OP_BRA,   BR_WAIT);
        step(0, 1, OP_ADD,    3, 1, 2, 0,  0, 0, 0, OP_NOP,   FLUSH);
        // not-taken BRA: OR r10 issues during BR_WAIT
        step(0, 1, OP_BRA,    0, 1, 0, 0,  0, 0, 0, OP_NOP,   RUN);
        step(0, 1, OP_OR,    10, 1, 2, 0,  0, 0, 1, OP_BRA,   BR_WAIT);
        // JUMP (rs1 field r10 unused); wrong path reads r10 -> no stall
        step(0, 1, OP_JUMP,   0,10, 0, 0,  0, 0, 1, OP_OR,    RUN);
        step(0, 1, OP_ADD,   11,10,10, 0,  0, 1, 1, OP_JUMP,  BR_WAIT);
        step(0, 1, OP_ADD,   11,10,10, 0,  0, 0, 0, OP_NOP,   FLUSH);
        // reset in the middle of a stall
        step(0, 1, OP_ADD,    3, 1, 2, 0,  0, 0, 0, OP_NOP,   RUN);
        step(0, 1, OP_SUB,    4, 3, 5, 0,  1, 0, 1, OP_ADD,   RUN);
        step(0, 1, OP_SUB,    4, 3, 5, 0,  1, 0, 0, OP_NOP,   STALL);
        step(1, 1, OP_SUB,    4, 3, 5, 0,  0, 0, 0, OP_NOP,   RUN);
        step(0, 1, OP_ADD,    5, 3, 4, 0,  0, 0, 0, OP_NOP,   RUN);
        // undefined opcode: no stall, never issued valid
        step(0, 1, 6'd63,     5, 5, 5, 0,  0, 0, 1, OP_ADD,   RUN);
        step(0, 0, OP_NOP,    0, 0, 0, 0,  0, 0, 0, OP_NOP,   RUN);
        step(0, 0, OP_NOP,    0, 0, 0, 0,  0, 0, 0, OP_NOP,   RUN);
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() == 0)
            passes++;
        else
            $display("FAIL drain left=%0d required=0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
